base_vlat_pipe: RTL
===================

BASE_VLAT_PIPE -- requirements
Module: base_vlat_pipe

Interface
REQ-001 Parameter: width, default 1, data bits per stage.
REQ-002 Parameter: depth, default 2, number of register stages, legal range 1..16.
REQ-003 Parameter: rstv, default 0, width-bit reset value of every stage data register.
REQ-004 Parameter: cw, default 5, occupancy-count width, at least clog2(depth+1).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk by the user.
REQ-007 flush  input  1  synchronous discard of all held entries.
REQ-008 i_v  input  1  upstream valid.
REQ-009 i_r  output  1  upstream ready.
REQ-010 i_d  input  [0:width-1]  upstream data.
REQ-011 o_v  output  1  downstream valid, equal to last-stage valid.
REQ-012 o_r  input  1  downstream ready.
REQ-013 o_d  output  [0:width-1]  last-stage data register, driven directly from a flop.
REQ-014 o_cnt  output  [0:cw-1]  registered count of valid stages, 0..depth.

Function
REQ-015 Stage k (0 = input side, depth-1 = output side) SHALL hold one valid bit v[k] and one data register d[k].
REQ-016 Advance signals: adv[depth-1] = v[depth-1] & o_r; adv[k] = v[k] & (~v[k+1] | adv[k+1]) for k < depth-1.
REQ-017 Stage k+1 SHALL load d[k] and set v[k+1] when adv[k]; stage 0 SHALL load i_d when i_v & i_r.
REQ-018 A stage SHALL clear its valid bit when it advances and is not reloaded in the same cycle.
REQ-019 d[k] SHALL change only on a load; d[k] is not zeroed when v[k] clears.
REQ-020 i_r = ~flush & (~v[0] | adv[0]); this is a combinational path from o_r through the chain.
REQ-021 Bubble collapse: an empty stage SHALL accept from its predecessor regardless of o_r.
REQ-022 Latency: with o_r=1 and the pipe empty, a word accepted at edge N SHALL appear on o_v/o_d after edge N+depth-1.
REQ-023 Throughput: one word per cycle SHALL be sustained when o_r=1 continuously.
REQ-024 Ordering: words SHALL leave in acceptance order, with no loss or duplication.
REQ-025 Stall: with o_r=0, the pipe SHALL fill to depth words, then drive i_r=0; o_d SHALL hold stable while o_v=1 and o_r=0.
REQ-026 Flush: when flush=1 at an edge, all v[k] SHALL clear, and no input or output transfer SHALL be counted that cycle.
REQ-027 During flush, o_v still reflects v[depth-1]; downstream SHALL treat an o_v&o_r handshake in a flush cycle as void.
REQ-028 o_cnt SHALL update each edge: +1 on input transfer, -1 on output transfer, unchanged when both or neither occur, 0 after flush.
REQ-029 o_cnt SHALL never exceed depth or go below 0; either condition is an assertion failure.
REQ-030 depth=1 SHALL degenerate to a single enable register with i_r = ~flush & (~v[0] | o_r).

Reset
REQ-031 On reset_n=0, all v[k], o_v and o_cnt SHALL go to 0 immediately, without waiting for clk.
REQ-032 On reset_n=0, all d[k] and o_d SHALL go to rstv immediately.
REQ-033 While reset_n=0, i_r SHALL read 1 unless flush=1, but no state changes.
REQ-034 Reset mid-transfer SHALL discard all in-flight words; the first edge after release behaves as an empty pipe.

Verification
REQ-035 Streaming (depth=3, width=8): o_r=1, i_v=1 with i_d=0x01,0x02,... -> o_v rises after the 3rd edge; o_d=0x01,0x02,... one per cycle; i_r constantly 1.
REQ-036 Backpressure (depth=3): o_r=0, push 4 words -> i_r=0 after the 3rd accept and o_cnt=3; then raise o_r -> 0x01,0x02,0x03 drain in order, and i_r=1 the same cycle o_r rises.
REQ-037 Bubble collapse: push one word, o_r=0 for 5 cycles -> word sits in stage 2 with o_cnt=1; a 2nd word pushed reaches stage 1 on the next edge.
REQ-038 Flush with a full pipe: flush=1 for 1 cycle while i_v=1 -> i_r=0 that cycle; next cycle o_v=0 and o_cnt=0; the word presented during flush is not accepted.
REQ-039 Async reset: with 2 words held, pulse reset_n low between edges -> o_v=0, o_cnt=0, o_d=rstv before the next edge.
REQ-040 Random stimulus: random i_v/o_r/flush over 10k cycles against a FIFO scoreboard -> order preserved, o_cnt matches the model, and o_d stable under stall.

Source files
------------

// File: rtl/base_vlat_pipe.sv
// Valid/ready register pipeline with bubble collapse, synchronous flush and a registered occupancy count.
// Latency depth-1 cycles from accept to o_v when empty; i_r is combinational from o_r down the stage chain.
module base_vlat_pipe #(
   parameter int               width = 1,
   parameter int               depth = 2,
   parameter logic [0:width-1] rstv  = '0,
   parameter int               cw    = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             i_v,
   output logic             i_r,
   input  logic [0:width-1] i_d,
   output logic             o_v,
   input  logic             o_r,
   output logic [0:width-1] o_d,
   output logic [0:cw-1]    o_cnt
);

   localparam logic [0:cw-1] depth_c = cw'(depth);

   logic [depth-1:0] v;
   logic [depth-1:0] adv;
   logic [depth-1:0] ld;
   logic [0:width-1] d [depth];
   logic [0:cw-1]    cnt;
   logic             in_xfer;
   logic             out_xfer;

   // Walk from the output side: a stage may move when the one ahead is empty or moving itself.
   always_comb begin
      logic go;
      go  = o_r;
      adv = '0;
      for (int k = depth - 1; k >= 0; k--) begin
         adv[k] = v[k] & go;
         go     = ~v[k] | adv[k];
      end
   end

   assign i_r      = ~flush & (~v[0] | adv[0]);
   assign in_xfer  = i_v & i_r;
   assign out_xfer = v[depth-1] & o_r & ~flush;

   always_comb begin
      ld    = '0;
      ld[0] = in_xfer;
      for (int k = 1; k < depth; k++) begin
         ld[k] = adv[k-1] & ~flush;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v <= '0;
      end else if (flush) begin
         v <= '0;
      end else begin
         v <= ld | (v & ~adv);
      end
   end

   // Data registers only move on a load, so o_d holds its last word when a stage empties.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < depth; k++) begin
            d[k] <= rstv;
         end
      end else begin
         if (ld[0]) begin
            d[0] <= i_d;
         end
         for (int k = 1; k < depth; k++) begin
            if (ld[k]) begin
               d[k] <= d[k-1];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else if (in_xfer && !out_xfer) begin
         cnt <= cnt + cw'(1);
      end else if (out_xfer && !in_xfer) begin
         cnt <= cnt - cw'(1);
      end
   end

   assign o_v   = v[depth-1];
   assign o_d   = d[depth-1];
   assign o_cnt = cnt;

   a_cnt_max : assert property (@(posedge clk) disable iff (!reset_n) cnt <= depth_c);
   a_no_over : assert property (@(posedge clk) disable iff (!reset_n)
                                !(cnt == depth_c && in_xfer && !out_xfer));
   a_no_under : assert property (@(posedge clk) disable iff (!reset_n)
                                 !(cnt == '0 && out_xfer && !in_xfer));
   a_cnt_match : assert property (@(posedge clk) disable iff (!reset_n)
                                  int'(cnt) == $countones(v));

endmodule
